write_chan_mngr_gen: RTL and testbench

WRITE_CHAN_MNGR_GEN -- requirements
Module: write_chan_mngr_gen

---
 rtl/write_chan_mngr_gen.sv | 223 ++++++++++++++++++++++
 tb/tb_write_chan_mngr_gen.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_chan_mngr_gen.sv
// Write channel manager. Queues write requests, wins the bus through an arbiter, issues AW
// and W bursts, and retires bursts on in-order B responses with an ID/status check.
module write_chan_mngr_gen #(
    parameter logic [1:0]  REQC_M_ID = 2'b00,
    parameter int unsigned DW        = 32,
    parameter int unsigned BEATS     = 4,
    parameter int unsigned OUTS      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  req_rq,
    input  logic                  gnt_rq,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [3:0]            awid,
    output logic [31:0]           awaddr,
    output logic [5:0]            awatop,
    output logic                  wvalid,
    input  logic                  wready,
    output logic [DW-1:0]         wdata,
    output logic                  wlast,
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [3:0]            bid,
    input  logic                  bcomp,
    input  logic                  wstart_rq,
    input  logic [31:0]           win_addr,
    input  logic [DW*BEATS-1:0]   in_wdata,
    output logic                  wbusy,
    output logic                  finish_wresp,
    output logic                  wresp_err
);
    localparam int unsigned CntW = $clog2(OUTS + 1);
    localparam int unsigned PtrW = (OUTS > 1) ? $clog2(OUTS) : 1;
    localparam int unsigned BcW  = $clog2(BEATS);
    localparam logic [CntW-1:0] OutsCnt  = CntW'(OUTS);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(OUTS - 1);
    localparam logic [BcW-1:0]  LastBeat = BcW'(BEATS - 1);

    typedef logic [BEATS-1:0][DW-1:0] burst_t;
    typedef enum logic [1:0] {StIdle, StReq, StAddr} aw_state_e;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    aw_state_e aw_state_q, aw_state_d;

    // Request FIFO: accepted but not yet addressed
    logic [31:0]     rq_addr_q [OUTS];
    logic [31:0]     rq_addr_d [OUTS];
    burst_t          rq_data_q [OUTS];
    burst_t          rq_data_d [OUTS];
    logic [PtrW-1:0] rq_wr_ptr_q, rq_wr_ptr_d, rq_rd_ptr_q, rq_rd_ptr_d;
    logic [CntW-1:0] rq_cnt_q, rq_cnt_d;

    // W queue: addressed bursts waiting for or sending data
    logic [3:0]      wq_id_q [OUTS];
    logic [3:0]      wq_id_d [OUTS];
    burst_t          wq_data_q [OUTS];
    burst_t          wq_data_d [OUTS];
    logic [PtrW-1:0] wq_wr_ptr_q, wq_wr_ptr_d, wq_rd_ptr_q, wq_rd_ptr_d;
    logic [CntW-1:0] wq_cnt_q, wq_cnt_d;

    // B-expect queue: data sent, response outstanding
    logic [3:0]      bq_id_q [OUTS];
    logic [3:0]      bq_id_d [OUTS];
    logic [PtrW-1:0] bq_wr_ptr_q, bq_wr_ptr_d, bq_rd_ptr_q, bq_rd_ptr_d;
    logic [CntW-1:0] bq_cnt_q, bq_cnt_d;

    logic [1:0]      seq_q, seq_d;
    logic [BcW-1:0]  beat_cnt_q, beat_cnt_d;
    logic [CntW-1:0] infl_q, infl_d;
    logic            fin_q, fin_d;
    logic            err_q, err_d;

    logic       busy, rq_push, aw_hs, w_act, w_hs, w_done, b_act, b_hs;
    logic [3:0] cur_id;

    always_comb begin
        busy    = (rq_cnt_q == OutsCnt) || (infl_q == OutsCnt);
        rq_push = wstart_rq && !busy;
        aw_hs   = (aw_state_q == StAddr) && awready;
        w_act   = (wq_cnt_q != '0);
        w_hs    = w_act && wready;
        w_done  = w_hs && (beat_cnt_q == LastBeat);
        b_act   = (bq_cnt_q != '0);
        b_hs    = b_act && bvalid;
        cur_id  = {REQC_M_ID, seq_q};
    end

    always_comb begin
        aw_state_d = aw_state_q;
        unique case (aw_state_q)
            StIdle: begin
                if (rq_cnt_q != '0 && infl_q < OutsCnt) aw_state_d = StReq;
            end
            StReq: begin
                if (gnt_rq) aw_state_d = StAddr;
            end
            StAddr: begin
                if (awready) aw_state_d = StIdle;
            end
            default: aw_state_d = StIdle;
        endcase
    end

    always_comb begin
        rq_addr_d   = rq_addr_q;
        rq_data_d   = rq_data_q;
        rq_wr_ptr_d = rq_wr_ptr_q;
        rq_rd_ptr_d = rq_rd_ptr_q;
        rq_cnt_d    = rq_cnt_q + CntW'(rq_push) - CntW'(aw_hs);
        if (rq_push) begin
            rq_addr_d[rq_wr_ptr_q] = win_addr;
            rq_data_d[rq_wr_ptr_q] = in_wdata;
            rq_wr_ptr_d            = ptr_inc(rq_wr_ptr_q);
        end
        if (aw_hs) rq_rd_ptr_d = ptr_inc(rq_rd_ptr_q);
    end

    // The W queue is filled on the AW handshake, so data can never lead its address.
    always_comb begin
        wq_id_d     = wq_id_q;
        wq_data_d   = wq_data_q;
        wq_wr_ptr_d = wq_wr_ptr_q;
        wq_rd_ptr_d = wq_rd_ptr_q;
        wq_cnt_d    = wq_cnt_q + CntW'(aw_hs) - CntW'(w_done);
        if (aw_hs) begin
            wq_id_d[wq_wr_ptr_q]   = cur_id;
            wq_data_d[wq_wr_ptr_q] = rq_data_q[rq_rd_ptr_q];
            wq_wr_ptr_d            = ptr_inc(wq_wr_ptr_q);
        end
        if (w_done) wq_rd_ptr_d = ptr_inc(wq_rd_ptr_q);

        if (w_done) begin
            beat_cnt_d = '0;
        end else if (w_hs) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end else begin
            beat_cnt_d = beat_cnt_q;
        end
    end

    always_comb begin
        bq_id_d     = bq_id_q;
        bq_wr_ptr_d = bq_wr_ptr_q;
        bq_rd_ptr_d = bq_rd_ptr_q;
        bq_cnt_d    = bq_cnt_q + CntW'(w_done) - CntW'(b_hs);
        if (w_done) begin
            bq_id_d[bq_wr_ptr_q] = wq_id_q[wq_rd_ptr_q];
            bq_wr_ptr_d          = ptr_inc(bq_wr_ptr_q);
        end
        if (b_hs) bq_rd_ptr_d = ptr_inc(bq_rd_ptr_q);

        seq_d  = seq_q + 2'(aw_hs);
        infl_d = infl_q + CntW'(aw_hs) - CntW'(b_hs);
        fin_d  = b_hs;
        err_d  = b_hs && (!bcomp || (bid != bq_id_q[bq_rd_ptr_q]));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aw_state_q  <= StIdle;
            rq_wr_ptr_q <= '0;
            rq_rd_ptr_q <= '0;
            rq_cnt_q    <= '0;
            wq_wr_ptr_q <= '0;
            wq_rd_ptr_q <= '0;
            wq_cnt_q    <= '0;
            bq_wr_ptr_q <= '0;
            bq_rd_ptr_q <= '0;
            bq_cnt_q    <= '0;
            seq_q       <= '0;
            beat_cnt_q  <= '0;
            infl_q      <= '0;
            fin_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            aw_state_q  <= aw_state_d;
            rq_wr_ptr_q <= rq_wr_ptr_d;
            rq_rd_ptr_q <= rq_rd_ptr_d;
            rq_cnt_q    <= rq_cnt_d;
            wq_wr_ptr_q <= wq_wr_ptr_d;
            wq_rd_ptr_q <= wq_rd_ptr_d;
            wq_cnt_q    <= wq_cnt_d;
            bq_wr_ptr_q <= bq_wr_ptr_d;
            bq_rd_ptr_q <= bq_rd_ptr_d;
            bq_cnt_q    <= bq_cnt_d;
            seq_q       <= seq_d;
            beat_cnt_q  <= beat_cnt_d;
            infl_q      <= infl_d;
            fin_q       <= fin_d;
            err_q       <= err_d;
        end
    end

    // Queue payload needs no reset; occupancy counts alone decide validity.
    always_ff @(posedge clk) begin
        rq_addr_q <= rq_addr_d;
        rq_data_q <= rq_data_d;
        wq_id_q   <= wq_id_d;
        wq_data_q <= wq_data_d;
        bq_id_q   <= bq_id_d;
    end

    // Outputs are forced low while rst_n is asserted and data buses are zero when not valid.
    always_comb begin
        req_rq       = rst_n && (aw_state_q == StReq);
        awvalid      = rst_n && (aw_state_q == StAddr);
        awid         = awvalid ? cur_id : '0;
        awaddr       = awvalid ? rq_addr_q[rq_rd_ptr_q] : '0;
        awatop       = '0;
        wvalid       = rst_n && w_act;
        wdata        = wvalid ? wq_data_q[wq_rd_ptr_q][beat_cnt_q] : '0;
        wlast        = wvalid && (beat_cnt_q == LastBeat);
        bready       = rst_n && b_act;
        wbusy        = rst_n && busy;
        finish_wresp = rst_n && fin_q;
        wresp_err    = rst_n && err_q;
    end

endmodule

// File: tb/tb_write_chan_mngr_gen.sv
// Directed bench for write_chan_mngr_gen: default instance plus a DW=64/BEATS=8/OUTS=4 instance.
module tb_write_chan_mngr_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    int          total, bad;

    logic        req_rq, gnt_rq, awvalid, awready, wvalid, wready, wlast;
    logic        bvalid, bready, bcomp, wstart_rq, wbusy, finish_wresp, wresp_err;
    logic [3:0]  awid, bid;
    logic [31:0] awaddr, win_addr, wdata;
    logic [5:0]  awatop;
    logic [127:0] in_wdata;

    logic        req_rq2, gnt_rq2, awvalid2, awready2, wvalid2, wready2, wlast2;
    logic        bvalid2, bready2, bcomp2, wstart_rq2, wbusy2, finish_wresp2, wresp_err2;
    logic [3:0]  awid2, bid2;
    logic [31:0] awaddr2, win_addr2;
    logic [63:0] wdata2;
    logic [5:0]  awatop2;
    logic [511:0] in_wdata2;

    write_chan_mngr_gen u_dut (
        .clk(clk), .rst_n(rst_n), .req_rq(req_rq), .gnt_rq(gnt_rq),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awatop(awatop),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bcomp(bcomp),
        .wstart_rq(wstart_rq), .win_addr(win_addr), .in_wdata(in_wdata),
        .wbusy(wbusy), .finish_wresp(finish_wresp), .wresp_err(wresp_err)
    );

    write_chan_mngr_gen #(
        .REQC_M_ID(2'b10), .DW(64), .BEATS(8), .OUTS(4)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req_rq(req_rq2), .gnt_rq(gnt_rq2),
        .awvalid(awvalid2), .awready(awready2), .awid(awid2), .awaddr(awaddr2),
        .awatop(awatop2), .wvalid(wvalid2), .wready(wready2), .wdata(wdata2), .wlast(wlast2),
        .bvalid(bvalid2), .bready(bready2), .bid(bid2), .bcomp(bcomp2),
        .wstart_rq(wstart_rq2), .win_addr(win_addr2), .in_wdata(in_wdata2),
        .wbusy(wbusy2), .finish_wresp(finish_wresp2), .wresp_err(wresp_err2)
    );

    // Handshake logs, sampled mid-cycle; each entry is a transfer at the next rising edge.
    logic [35:0] aw_log[$];
    logic [32:0] w_log[$];
    logic [3:0]  aw_log2[$];
    logic [64:0] w_log2[$];
    int          fin_n;

    always @(negedge clk) begin
        if (awvalid && awready) aw_log.push_back({awid, awaddr});
        if (wvalid && wready) w_log.push_back({wlast, wdata});
        if (finish_wresp) fin_n++;
        if (awvalid2 && awready2) aw_log2.push_back(awid2);
        if (wvalid2 && wready2) w_log2.push_back({wlast2, wdata2});
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        aw_log.delete();
        w_log.delete();
    endtask

    function automatic logic [255:0] outs1();
        return 256'({req_rq, awvalid, awid, awaddr, awatop, wvalid, wdata, wlast,
                     bready, wbusy, finish_wresp, wresp_err});
    endfunction

    function automatic logic [255:0] outs2();
        return 256'({req_rq2, awvalid2, awid2, awaddr2, awatop2, wvalid2, wdata2, wlast2,
                     bready2, wbusy2, finish_wresp2, wresp_err2});
    endfunction

    logic        stall;
    logic [31:0] held;
    int          fin_base;

    initial begin
        total = 0; bad = 0; fin_n = 0;
        rst_n = 1'b0;
        gnt_rq = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bcomp = 1'b0;
        wstart_rq = 1'b0; win_addr = '0; in_wdata = '0;
        gnt_rq2 = 1'b1; awready2 = 1'b1; wready2 = 1'b0; bvalid2 = 1'b0; bid2 = '0;
        bcomp2 = 1'b1; wstart_rq2 = 1'b0; win_addr2 = 32'h8000;
        for (int k = 0; k < 8; k++) in_wdata2[k*64 +: 64] = 64'hC0DE_0000_0000_0000 + 64'(k);

        // Reset: outputs low during and right after reset
        step(1);
        chk("rst_outs", outs1(), 256'(0));
        chk("rst_outs2", outs2(), 256'(0));
        step(1);
        rst_n = 1'b1;
        step(1);
        chk("post_rst_outs", outs1(), 256'(0));

        // Single write with everything ready
        gnt_rq = 1'b1; awready = 1'b1; wready = 1'b1;
        win_addr = 32'h1000;
        in_wdata = 128'h00000044_00000033_00000022_00000011;
        wstart_rq = 1'b1;
        step(1);
        wstart_rq = 1'b0;
        chk("t1_wbusy", 256'(wbusy), 256'(0));
        step(1);
        chk("t1_req", 256'({req_rq, awvalid}), 256'(2'b10));
        step(1);
        chk("t1_aw", 256'({awvalid, awid, awaddr, awatop}), 256'({1'b1, 4'h0, 32'h1000, 6'h0}));
        step(1);
        chk("t1_w0", 256'({awvalid, wvalid, wdata, wlast}), 256'({1'b0, 1'b1, 32'h11, 1'b0}));
        step(3);
        chk("t1_w3", 256'({wvalid, wdata, wlast}), 256'({1'b1, 32'h44, 1'b1}));
        step(1);
        chk("t1_bready", 256'({wvalid, bready}), 256'(2'b01));
        chk("t1_nbeats", 256'(w_log.size()), 256'(4));
        chk("t1_beats", 256'({w_log[0], w_log[1], w_log[2], w_log[3]}),
            256'({1'b0, 32'h11, 1'b0, 32'h22, 1'b0, 32'h33, 1'b1, 32'h44}));
        bvalid = 1'b1; bid = 4'h0; bcomp = 1'b1;
        step(1);
        bvalid = 1'b0;
        chk("t1_fin", 256'({finish_wresp, wresp_err, bready}), 256'(3'b100));
        step(1);
        chk("t1_fin_pulse", 256'(finish_wresp), 256'(0));

        // Fill: no grant, third request dropped
        do_reset();
        gnt_rq = 1'b0;
        win_addr = 32'hA000; in_wdata = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
        wstart_rq = 1'b1;
        step(1);
        chk("t2_busy1", 256'(wbusy), 256'(0));
        win_addr = 32'hB000; in_wdata = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
        step(1);
        chk("t2_busy2", 256'(wbusy), 256'(1));
        win_addr = 32'hC000; in_wdata = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;
        step(1);
        wstart_rq = 1'b0;
        chk("t2_busy3", 256'({wbusy, req_rq}), 256'(2'b11));
        gnt_rq = 1'b1;
        step(12);
        chk("t2_naw", 256'(aw_log.size()), 256'(2));
        chk("t2_aws", 256'({aw_log[0], aw_log[1]}), 256'({4'h0, 32'hA000, 4'h1, 32'hB000}));
        chk("t2_inflight", 256'({wbusy, bready, req_rq}), 256'(3'b110));
        chk("t2_nbeats", 256'(w_log.size()), 256'(8));
        chk("t2_bbeats", 256'({w_log[4], w_log[7]}), 256'({1'b0, 32'hB0B0B0B0, 1'b1, 32'hB3B3B3B3}));
        bvalid = 1'b1; bid = 4'h0; bcomp = 1'b1;
        step(1);
        chk("t2_fin_a", 256'({finish_wresp, wresp_err, wbusy}), 256'(3'b100));
        bid = 4'h1;
        step(1);
        bvalid = 1'b0;
        chk("t2_fin_b", 256'({finish_wresp, wresp_err, bready}), 256'(3'b100));

        // Backpressure on W, then error responses
        do_reset();
        wready = 1'b0;
        win_addr = 32'h2000; in_wdata = 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001;
        wstart_rq = 1'b1;
        step(1);
        wstart_rq = 1'b0;
        stall = 1'b0; held = '0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (stall) chk("t3_hold", 256'(wdata), 256'(held));
            wready = i[0];
            stall = wvalid && !wready;
            held = wdata;
        end
        chk("t3_nbeats", 256'(w_log.size()), 256'(4));
        chk("t3_beats", 256'({w_log[0], w_log[1], w_log[2], w_log[3]}),
            256'({1'b0, 32'hAAAA0001, 1'b0, 32'hBBBB0002, 1'b0, 32'hCCCC0003, 1'b1, 32'hDDDD0004}));
        bvalid = 1'b1; bid = 4'h0; bcomp = 1'b0;
        step(1);
        bvalid = 1'b0;
        chk("t3_err_comp", 256'({finish_wresp, wresp_err}), 256'(2'b11));
        wready = 1'b1; win_addr = 32'h2100;
        wstart_rq = 1'b1;
        step(1);
        wstart_rq = 1'b0;
        step(10);
        chk("t3_aw2", 256'(aw_log[1]), 256'({4'h1, 32'h2100}));
        bvalid = 1'b1; bid = 4'h0; bcomp = 1'b1;
        step(1);
        bvalid = 1'b0;
        chk("t3_err_id", 256'({finish_wresp, wresp_err}), 256'(2'b11));
        step(1);
        chk("t3_quiet", 256'({finish_wresp, wresp_err, bready, wbusy}), 256'(0));

        // Reset in the middle of a burst
        do_reset();
        win_addr = 32'h3000; in_wdata = 128'h33333333_22222222_11111111_00000000;
        wstart_rq = 1'b1;
        step(1);
        wstart_rq = 1'b0;
        step(5);
        chk("t4_two_beats", 256'(w_log.size()), 256'(2));
        rst_n = 1'b0;
        #1;
        chk("t4_in_rst", outs1(), 256'(0));
        step(1);
        rst_n = 1'b1;
        chk("t4_after_rst", outs1(), 256'(0));
        fin_base = fin_n;
        bvalid = 1'b1; bid = 4'h0; bcomp = 1'b1;
        step(3);
        bvalid = 1'b0;
        chk("t4_b_ignored", 256'({bready, 32'(fin_n - fin_base)}), 256'(0));
        win_addr = 32'h3100;
        wstart_rq = 1'b1;
        step(1);
        wstart_rq = 1'b0;
        step(10);
        chk("t4_aw_new", 256'({32'(aw_log.size()), aw_log[1]}), 256'({32'd2, 4'h0, 32'h3100}));
        chk("t4_beats", 256'({32'(w_log.size()), w_log[5]}), 256'({32'd6, 1'b1, 32'h33333333}));
        bvalid = 1'b1; bid = 4'h0; bcomp = 1'b1;
        step(1);
        bvalid = 1'b0;
        chk("t4_fin", 256'({finish_wresp, wresp_err}), 256'(2'b10));

        // Wide instance: four bursts in flight, ID wrap
        wstart_rq2 = 1'b1;
        step(4);
        wstart_rq2 = 1'b0;
        step(12);
        chk("t5_naw", 256'(aw_log2.size()), 256'(4));
        chk("t5_ids", 256'({aw_log2[0], aw_log2[1], aw_log2[2], aw_log2[3]}), 256'(16'h89AB));
        chk("t5_busy", 256'(wbusy2), 256'(1));
        wstart_rq2 = 1'b1;
        step(1);
        wstart_rq2 = 1'b0;
        wready2 = 1'b1;
        step(40);
        chk("t5_nbeats", 256'(w_log2.size()), 256'(32));
        chk("t5_beat0", 256'(w_log2[0]), 256'({1'b0, 64'hC0DE_0000_0000_0000}));
        chk("t5_beat7", 256'(w_log2[7]), 256'({1'b1, 64'hC0DE_0000_0000_0007}));
        bvalid2 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bid2 = 4'h8 + 4'(k);
            step(1);
            chk("t5_fin", 256'({finish_wresp2, wresp_err2}), 256'(2'b10));
        end
        bvalid2 = 1'b0;
        chk("t5_unbusy", 256'(wbusy2), 256'(0));
        wstart_rq2 = 1'b1;
        step(1);
        wstart_rq2 = 1'b0;
        step(6);
        chk("t5_wrap_n", 256'(aw_log2.size()), 256'(5));
        chk("t5_wrap_id", 256'(aw_log2[4]), 256'(4'h8));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
